// File: rtl/uc_arbiter.sv
// uc_arbiter: round-robin unit clause pop, duplicate/conflict filter and literal broadcast
module uc_arbiter #(
   parameter int NUM_ENG = 4,
   parameter int DATA_LEN = 512,
   parameter int HIST_DEPTH = 16,
   localparam int LW = $clog2(DATA_LEN),
   localparam int PW = $clog2(NUM_ENG),
   localparam int CW = $clog2(HIST_DEPTH + 1),
   localparam int HW = $clog2(HIST_DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic [NUM_ENG-1:0]   q_empty,
   output logic [NUM_ENG-1:0]   q_pop,
   input  logic signed [LW-1:0] q_data [NUM_ENG],
   output logic                 out_valid,
   output logic signed [LW-1:0] out_lit,
   input  logic                 out_ready,
   output logic                 conflict,
   output logic signed [LW-1:0] conflict_lit,
   output logic                 hist_full,
   output logic                 busy
);
   logic [PW-1:0] rr_ptr, gnt, nxt_ptr;
   logic [CW-1:0] hist_cnt;
   logic signed [LW-1:0] hist [HIST_DEPTH];
   logic signed [LW-1:0] lit, neg;
   logic any, pop, dup, neg_hit, full, halted;

   assign halted = conflict | hist_full;
   assign full = hist_cnt == CW'(HIST_DEPTH);
   assign lit = q_data[gnt];
   assign neg = -lit;
   assign pop = rst && !halted && !clear && (!out_valid || out_ready) && any;
   assign q_pop = pop ? (NUM_ENG'(1) << gnt) : '0;
   assign nxt_ptr = (gnt == PW'(NUM_ENG - 1)) ? '0 : gnt + 1'b1;
   assign busy = rst && !halted && (out_valid || !(&q_empty));

   // first non-empty queue scanning from rr_ptr; descending loop lets the nearest win
   always_comb begin
      logic [PW-1:0] idx;
      idx = '0;
      gnt = '0;
      any = 1'b0;
      for (int i = NUM_ENG - 1; i >= 0; i--) begin
         idx = PW'((int'(rr_ptr) + i) % NUM_ENG);
         if (!q_empty[idx]) begin
            gnt = idx;
            any = 1'b1;
         end
      end
   end

   // compare the candidate literal and its negation against the valid history entries
   always_comb begin
      dup = 1'b0;
      neg_hit = 1'b0;
      for (int i = 0; i < HIST_DEPTH; i++) begin
         if (CW'(i) < hist_cnt) begin
            dup = dup | (hist[i] == lit);
            neg_hit = neg_hit | (hist[i] == neg);
         end
      end
   end

   // history storage needs no reset; only entries below hist_cnt are ever read
   always_ff @(posedge clk) begin
      if (pop && !neg_hit && !dup && !full) hist[HW'(hist_cnt)] <= lit;
   end

   // control, flags and output register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr <= '0;
         hist_cnt <= '0;
         conflict <= 1'b0;
         conflict_lit <= '0;
         hist_full <= 1'b0;
         out_valid <= 1'b0;
         out_lit <= '0;
      end else if (clear) begin
         rr_ptr <= '0;
         hist_cnt <= '0;
         conflict <= 1'b0;
         conflict_lit <= '0;
         hist_full <= 1'b0;
         out_valid <= 1'b0;
      end else if (pop) begin
         rr_ptr <= nxt_ptr;
         if (neg_hit) begin
            conflict <= 1'b1;
            conflict_lit <= lit;
            out_valid <= 1'b0;
         end else if (dup) begin
            out_valid <= 1'b0;
         end else if (full) begin
            hist_full <= 1'b1;
            out_valid <= 1'b0;
         end else begin
            hist_cnt <= hist_cnt + 1'b1;
            out_lit <= lit;
            out_valid <= 1'b1;
         end
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_uc_arbiter.sv
// tb_uc_arbiter: directed self-checking bench for uc_arbiter
module tb_uc_arbiter;
   logic clk = 1'b0;
   logic rst, clear, out_ready;
   logic [3:0] q_empty, q_pop;
   logic signed [8:0] q_data [4];
   logic out_valid, conflict, hist_full, busy;
   logic signed [8:0] out_lit, conflict_lit;
   int checks = 0, errors = 0;

   uc_arbiter dut (
      .clk(clk), .rst(rst), .clear(clear), .q_empty(q_empty), .q_pop(q_pop),
      .q_data(q_data), .out_valid(out_valid), .out_lit(out_lit), .out_ready(out_ready),
      .conflict(conflict), .conflict_lit(conflict_lit), .hist_full(hist_full), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      #1;
      chk("clear_nopop", q_pop, 0);
      tick();
      clear = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      clear = 1'b0;
      out_ready = 1'b1;
      q_empty = 4'b0000;
      for (int i = 0; i < 4; i++) q_data[i] = 9'sd1;
      tick();
      tick();
      chk("rst_pop", q_pop, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_lit", out_lit, 0);
      chk("rst_conflict", conflict, 0);
      chk("rst_clit", conflict_lit, 0);
      chk("rst_full", hist_full, 0);
      chk("rst_busy", busy, 0);
      q_empty = 4'b1111;
      #2 rst = 1'b1;
      tick();
      // single literal from queue 2
      q_empty = 4'b1011;
      q_data[2] = 9'sd5;
      #1;
      chk("single_pop", q_pop, 4'b0100);
      tick();
      q_empty = 4'b1111;
      #1;
      chk("single_valid", out_valid, 1);
      chk("single_lit", out_lit, 5);
      chk("single_pop_once", q_pop, 0);
      tick();
      chk("single_drain", out_valid, 0);
      chk("idle_busy", busy, 0);
      // round robin over all four queues
      do_clear();
      q_empty = 4'b0000;
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < 4; i++) q_data[i] = 9'(20 + 4 * k + i);
         #1;
         chk("rr_pop", q_pop, 1 << (k % 4));
         tick();
         chk("rr_valid", out_valid, 1);
         chk("rr_lit", out_lit, 20 + 4 * k + (k % 4));
      end
      // backpressure holds output and stops pops
      out_ready = 1'b0;
      q_data[1] = 9'sd40;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp_pop", q_pop, 0);
         chk("bp_lit", out_lit, 36);
         chk("bp_valid", out_valid, 1);
         tick();
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_pop", q_pop, 4'b0010);
      tick();
      q_empty = 4'b1111;
      chk("bp_next_lit", out_lit, 40);
      tick();
      chk("bp_drain", out_valid, 0);
      // duplicate then conflict
      do_clear();
      q_empty = 4'b1110;
      q_data[0] = 9'sd3;
      tick();
      chk("dup_first_valid", out_valid, 1);
      chk("dup_first_lit", out_lit, 3);
      q_empty = 4'b1101;
      q_data[1] = 9'sd3;
      #1;
      chk("dup_pop", q_pop, 4'b0010);
      tick();
      chk("dup_no_valid", out_valid, 0);
      chk("dup_no_conflict", conflict, 0);
      q_empty = 4'b1011;
      q_data[2] = -9'sd3;
      #1;
      chk("neg_pop", q_pop, 4'b0100);
      tick();
      chk("neg_conflict", conflict, 1);
      chk("neg_clit", conflict_lit, -3);
      chk("neg_valid", out_valid, 0);
      chk("neg_halt_pop", q_pop, 0);
      chk("neg_busy", busy, 0);
      tick();
      chk("neg_sticky", conflict, 1);
      chk("neg_halt_pop2", q_pop, 0);
      do_clear();
      chk("clr_conflict", conflict, 0);
      chk("clr_clit", conflict_lit, 0);
      q_data[2] = 9'sd3;
      #1;
      chk("clr_pop", q_pop, 4'b0100);
      tick();
      q_empty = 4'b1111;
      chk("clr_rebroadcast", out_valid, 1);
      chk("clr_relit", out_lit, 3);
      // literal zero is its own negation
      do_clear();
      q_empty = 4'b1110;
      q_data[0] = 9'sd0;
      tick();
      chk("zero_valid", out_valid, 1);
      chk("zero_lit", out_lit, 0);
      tick();
      chk("zero_conflict", conflict, 1);
      chk("zero_clit", conflict_lit, 0);
      // history overflow
      do_clear();
      for (int k = 1; k <= 16; k++) begin
         q_data[0] = 9'(k);
         #1;
         chk("ovf_fill_pop", q_pop, 4'b0001);
         tick();
      end
      chk("ovf_last_lit", out_lit, 16);
      chk("ovf_no_full", hist_full, 0);
      q_data[0] = 9'sd17;
      #1;
      chk("ovf_pop17", q_pop, 4'b0001);
      tick();
      chk("ovf_full", hist_full, 1);
      chk("ovf_valid", out_valid, 0);
      chk("ovf_lit_kept", out_lit, 16);
      chk("ovf_halt_pop", q_pop, 0);
      // asynchronous reset mid-stream
      do_clear();
      q_empty = 4'b0111;
      q_data[3] = 9'sd9;
      #1;
      chk("ar_pop", q_pop, 4'b1000);
      tick();
      out_ready = 1'b0;
      q_empty = 4'b0000;
      for (int i = 0; i < 4; i++) q_data[i] = 9'(50 + i);
      #1;
      chk("ar_pre_valid", out_valid, 1);
      #2 rst = 1'b0;
      #1;
      chk("ar_valid", out_valid, 0);
      chk("ar_pop_low", q_pop, 0);
      chk("ar_lit", out_lit, 0);
      chk("ar_busy", busy, 0);
      #1 rst = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("ar_restart", q_pop, 4'b0001);
      tick();
      chk("ar_restart_lit", out_lit, 50);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
